// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches words over a req/ack handshake,
// holds each instruction for the decoder until it retires, and flags misaligned redirects.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        fetch_fault,
    output logic [31:0] instret
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        VALID = 2'd2,
        FAULT = 2'd3
    } state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    function automatic logic word_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

    state_t      state_r, state_nxt_s;
    logic [31:0] pc_r, pc_nxt_s;
    logic [31:0] pc_plus4_r;
    logic [31:0] imem_addr_r;
    logic [31:0] instr_r, instr_nxt_s;
    logic [31:0] instret_r, instret_nxt_s;
    logic        fault_r, fault_nxt_s;

    // Next-state and next-value decode for the fetch FSM.
    always_comb begin
        state_nxt_s   = state_r;
        pc_nxt_s      = pc_r;
        instr_nxt_s   = instr_r;
        instret_nxt_s = instret_r;
        fault_nxt_s   = fault_r;
        case (state_r)
            IDLE: begin
                state_nxt_s = REQ;
            end
            REQ: begin
                if (imem_ack) begin
                    instr_nxt_s = imem_rdata;
                    state_nxt_s = VALID;
                end else begin
                    state_nxt_s = REQ;
                end
            end
            VALID: begin
                if (instr_ready) begin
                    // A misaligned target still retires the instruction; pc keeps the bad target for debug.
                    instret_nxt_s = instret_r + 32'd1;
                    if (redirect) begin
                        pc_nxt_s = redirect_target;
                        if (word_aligned(redirect_target)) begin
                            state_nxt_s = REQ;
                        end else begin
                            fault_nxt_s = 1'b1;
                            state_nxt_s = FAULT;
                        end
                    end else begin
                        pc_nxt_s    = pc_plus4_r;
                        state_nxt_s = REQ;
                    end
                end else begin
                    state_nxt_s = VALID;
                end
            end
            FAULT: begin
                state_nxt_s = FAULT;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            pc_r        <= RESET_PC;
            pc_plus4_r  <= RESET_PC + 32'd4;
            imem_addr_r <= RESET_PC;
            instr_r     <= NOP_INSTR;
            instret_r   <= 32'd0;
            fault_r     <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            pc_r        <= pc_nxt_s;
            pc_plus4_r  <= pc_nxt_s + 32'd4;
            imem_addr_r <= pc_nxt_s;
            instr_r     <= instr_nxt_s;
            instret_r   <= instret_nxt_s;
            fault_r     <= fault_nxt_s;
        end
    end

    assign imem_req    = (state_r == REQ);
    assign instr_valid = (state_r == VALID);
    assign imem_addr   = imem_addr_r;
    assign instr       = instr_r;
    assign pc          = pc_r;
    assign pc_plus4    = pc_plus4_r;
    assign fetch_fault = fault_r;
    assign instret     = instret_r;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a small memory responder with programmable wait
// states plus a linear sequence of steps checked with immediate assertions.
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect;
    logic [31:0] redirect_target;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fetch_fault;
    logic [31:0] instret;

    int          n_tests;
    int          n_fail;
    int          mem_wait;
    int          wcnt;
    logic        stray_ack;
    logic [31:0] mem_data;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk             (clk),
        .reset           (reset),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .instr           (instr),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .pc              (pc),
        .pc_plus4        (pc_plus4),
        .fetch_fault     (fetch_fault),
        .instret         (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory acks once the request has been waiting mem_wait cycles; stray_ack injects unsolicited acks.
    always @(posedge clk) begin
        if (imem_req && !imem_ack) wcnt <= wcnt + 1;
        else wcnt <= 0;
    end
    assign imem_ack   = (imem_req && (wcnt == mem_wait)) || stray_ack;
    assign imem_rdata = mem_data;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        n_tests = 0; n_fail = 0; wcnt = 0;
        mem_wait = 0; stray_ack = 1'b0; mem_data = 32'h0000_0093;
        reset = 1'b1; instr_ready = 1'b1; redirect = 1'b0; redirect_target = 32'd0;
        tick(); tick();

        // Reset state
        chk("rst_req",     32'(imem_req),    32'd0);
        chk("rst_valid",   32'(instr_valid), 32'd0);
        chk("rst_pc",      pc,               32'h0000_0000);
        chk("rst_pc4",     pc_plus4,         32'h0000_0004);
        chk("rst_addr",    imem_addr,        32'h0000_0000);
        chk("rst_instr",   instr,            32'h0000_0013);
        chk("rst_fault",   32'(fetch_fault), 32'd0);
        chk("rst_instret", instret,          32'd0);

        // Zero-wait fetches with instr_ready held high
        reset = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("zw_req",     32'(imem_req),    32'd1);
            chk("zw_addr",    imem_addr,        32'(4 * i));
            chk("zw_nvalid",  32'(instr_valid), 32'd0);
            tick();
            chk("zw_valid",   32'(instr_valid), 32'd1);
            chk("zw_pc",      pc,               32'(4 * i));
            chk("zw_instr",   instr,            32'h0000_0093);
            tick();
            chk("zw_instret", instret,          32'(i + 1));
        end

        // Three wait states: request held 4 cycles at a stable address
        mem_wait = 3; mem_data = 32'h0040_0113; instr_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("ws_req",    32'(imem_req),    32'd1);
            chk("ws_addr",   imem_addr,        32'h0000_000C);
            chk("ws_nvalid", 32'(instr_valid), 32'd0);
            tick();
        end
        chk("ws_valid", 32'(instr_valid), 32'd1);
        chk("ws_instr", instr,            32'h0040_0113);

        // Stall in VALID; unqualified redirect and stray acks are ignored
        redirect = 1'b1; redirect_target = 32'h0000_0100;
        stray_ack = 1'b1; mem_data = 32'hDEAD_BEEF;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("hold_valid",   32'(instr_valid), 32'd1);
            chk("hold_req",     32'(imem_req),    32'd0);
            chk("hold_pc",      pc,               32'h0000_000C);
            chk("hold_instr",   instr,            32'h0040_0113);
            chk("hold_instret", instret,          32'd3);
        end
        stray_ack = 1'b0; mem_wait = 0; mem_data = 32'h0000_0093;

        // Redirect to 0x40, then from 0x40 to 0x100
        instr_ready = 1'b1; redirect_target = 32'h0000_0040;
        tick();
        chk("rd40_addr",    imem_addr, 32'h0000_0040);
        chk("rd40_pc4",     pc_plus4,  32'h0000_0044);
        chk("rd40_instret", instret,   32'd4);
        redirect = 1'b0;
        tick();
        chk("rd40_valid", 32'(instr_valid), 32'd1);
        chk("rd40_pc",    pc,               32'h0000_0040);
        redirect = 1'b1; redirect_target = 32'h0000_0100;
        tick();
        chk("rd100_addr", imem_addr,     32'h0000_0100);
        chk("rd100_pc4",  pc_plus4,      32'h0000_0104);
        chk("rd100_req",  32'(imem_req), 32'd1);
        redirect = 1'b0;
        tick();

        // Redirect with instr_ready low has no effect
        instr_ready = 1'b0; redirect = 1'b1; redirect_target = 32'h0000_0200;
        tick(); tick();
        chk("nord_pc",      pc,               32'h0000_0100);
        chk("nord_valid",   32'(instr_valid), 32'd1);
        chk("nord_instret", instret,          32'd5);

        // PC wrap at the top of the address space
        instr_ready = 1'b1; redirect_target = 32'hFFFF_FFFC;
        tick();
        chk("wrap_addr_top", imem_addr, 32'hFFFF_FFFC);
        chk("wrap_pc4_top",  pc_plus4,  32'h0000_0000);
        redirect = 1'b0;
        tick();
        tick();
        chk("wrap_addr0", imem_addr,        32'h0000_0000);
        chk("wrap_pc0",   pc,               32'h0000_0000);
        chk("wrap_fault", 32'(fetch_fault), 32'd0);
        chk("wrap_icnt",  instret,          32'd7);
        tick();

        // instret wrap from all-ones
        instr_ready = 1'b0;
        force dut.instret_r = 32'hFFFF_FFFF;
        #1;
        release dut.instret_r;
        #1;
        chk("icnt_pre", instret, 32'hFFFF_FFFF);
        mem_wait = 3; instr_ready = 1'b1;
        tick();
        chk("icnt_wrap", instret,       32'd0);
        chk("icnt_req",  32'(imem_req), 32'd1);
        chk("icnt_addr", imem_addr,     32'h0000_0004);

        // Reset during an outstanding request; an ack in IDLE is dropped
        reset = 1'b1;
        tick();
        chk("rreq_req",   32'(imem_req),    32'd0);
        chk("rreq_valid", 32'(instr_valid), 32'd0);
        chk("rreq_pc",    pc,               32'h0000_0000);
        reset = 1'b0; stray_ack = 1'b1; mem_data = 32'hDEAD_BEEF;
        tick();
        stray_ack = 1'b0; mem_wait = 0; mem_data = 32'h0000_0093;
        chk("rreq_req1",  32'(imem_req), 32'd1);
        chk("rreq_addr",  imem_addr,     32'h0000_0000);
        chk("rreq_instr", instr,         32'h0000_0013);
        tick();

        // Misaligned target faults and stays faulted until reset
        redirect = 1'b1; redirect_target = 32'h0000_0102;
        tick();
        chk("flt_fault",   32'(fetch_fault), 32'd1);
        chk("flt_pc",      pc,               32'h0000_0102);
        chk("flt_instret", instret,          32'd1);
        redirect = 1'b0; stray_ack = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("flt_sticky", 32'(fetch_fault), 32'd1);
            chk("flt_req",    32'(imem_req),    32'd0);
            chk("flt_valid",  32'(instr_valid), 32'd0);
            tick();
        end
        stray_ack = 1'b0;
        reset = 1'b1;
        tick();
        chk("flt_clr", 32'(fetch_fault), 32'd0);
        chk("flt_rpc", pc,               32'h0000_0000);
        reset = 1'b0;
        tick();
        chk("flt_restart_req",  32'(imem_req), 32'd1);
        chk("flt_restart_addr", imem_addr,     32'h0000_0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
